// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared types and constants for the fetch unit and its queue.
//   XLEN / INSTR_W : address and instruction widths
//   PC_STEP        : byte increment between sequential fetches
//   NOP_INSTR      : canonical NOP encoding (filler for benches)
//   fetch_entry_t  : one queued {pc, instr} pair
//   fetch_state_e  : RUN / HALT fetch state
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular buffer of fetch entries with push/pop/flush.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : drop all entries (wins over push/pop)
//   push        : write push_entry at the tail
//   pop         : advance the head
//   push_entry  : entry to store
//   head_entry  : entry at the head (meaningful only while count != 0)
//   count       : number of valid entries, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     storage_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only observable once
  // count covers it, so clearing the data would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (push && !flush) storage_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = storage_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// PC generator plus fetch queue in front of a 1024-word combinational-read
// instruction memory.
//   clk, reset         : clock, synchronous active-high reset
//   io_imem_addr       : word address {2'b00, pc[31:2]} (memory uses [9:0])
//   io_imem_data       : instruction returned in the same cycle
//   io_redirect_valid  : load io_redirect_pc, flush queue
//   io_redirect_pc     : byte-address redirect target
//   io_out_valid/ready : handshake toward decode
//   io_out_pc/instr    : head entry, from registered queue storage only
//   io_misaligned      : (FETCH_MISALIGN_TRAP_EN only) misaligned redirect seen
// Optional build macro: FETCH_MISALIGN_TRAP_EN. When undefined, the low two
// bits of a redirect target are forced to zero and the unit never halts.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] io_imem_addr,
  input  logic [31:0] io_imem_data,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_pc,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_pc,
  output logic [31:0] io_out_instr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        io_misaligned
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  fetch_state_e    state_q, state_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misaligned_q, misaligned_d;
`endif

  logic             push, pop, q_full, q_show;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     push_entry, head_entry;

  assign io_imem_addr = {2'b00, pc_q[31:2]};

  assign q_full = (q_count == CNT_W'(QUEUE_DEPTH));
  // Outputs are forced to zero while reset is high; afterwards the reset
  // queue is empty, which keeps them zero for the following cycle too.
  assign q_show = (q_count != '0) && !reset;

  // A redirect cycle never presents a valid head, so decode cannot accept
  // an entry that is being flushed.
  assign io_out_valid = q_show && !io_redirect_valid;
  assign io_out_pc    = q_show ? head_entry.pc    : '0;
  assign io_out_instr = q_show ? head_entry.instr : '0;

  assign pop  = io_out_valid && io_out_ready;
  assign push = !io_redirect_valid && (!q_full || pop) && (state_q == ST_RUN);

  assign push_entry = '{pc: pc_q, instr: io_imem_data};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif
    if (io_redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (io_redirect_pc[1:0] != 2'b00) begin
        pc_d         = io_redirect_pc;
        state_d      = ST_HALT;
        misaligned_d = 1'b1;
      end else begin
        pc_d         = io_redirect_pc;
        state_d      = ST_RUN;
        misaligned_d = 1'b0;
      end
`else
      pc_d    = io_redirect_pc & ~32'h3;
      state_d = ST_RUN;
`endif
    end else if (push) begin
      pc_d = pc_q + PC_STEP;  // wraps modulo 2^32
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign io_misaligned = misaligned_q;
`endif

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (io_redirect_valid),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue-based model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_imem_addr;
  logic [31:0] io_imem_data;
  logic        io_redirect_valid = 1'b0;
  logic [31:0] io_redirect_pc = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [31:0] io_out_pc;
  logic [31:0] io_out_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        io_misaligned;
`endif

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  assign io_imem_data = mem[io_imem_addr[9:0]];

  fetch_unit #(
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .io_imem_addr      (io_imem_addr),
    .io_imem_data      (io_imem_data),
    .io_redirect_valid (io_redirect_valid),
    .io_redirect_pc    (io_redirect_pc),
    .io_out_valid      (io_out_valid),
    .io_out_ready      (io_out_ready),
    .io_out_pc         (io_out_pc),
    .io_out_instr      (io_out_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .io_misaligned     (io_misaligned)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a plain FIFO of entries plus the next fetch address.
  fetch_entry_t mq [$];
  logic [31:0]  m_pc;
  logic         m_halt = 1'b0;

  // DUT outputs seen in the most recent step, for directed checks.
  logic        last_valid;
  logic [31:0] last_pc, last_instr, last_addr;

  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc,
                      input logic rdy);
    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr;
    @(negedge clk);
    reset             = rst;
    io_redirect_valid = rv;
    io_redirect_pc    = rpc;
    io_out_ready      = rdy;
    #1;
    exp_valid = !rst && !rv && (mq.size() != 0);
    exp_pc    = (!rst && mq.size() != 0) ? mq[0].pc    : 32'h0;
    exp_instr = (!rst && mq.size() != 0) ? mq[0].instr : 32'h0;
    last_valid = io_out_valid;
    last_pc    = io_out_pc;
    last_instr = io_out_instr;
    last_addr  = io_imem_addr;
    check("out_valid", 32'(io_out_valid), 32'(exp_valid));
    check("out_pc",    io_out_pc,    exp_pc);
    check("out_instr", io_out_instr, exp_instr);
    if (!rst) check("imem_addr", io_imem_addr, {2'b00, m_pc[31:2]});
`ifdef FETCH_MISALIGN_TRAP_EN
    if (!rst) check("misaligned", 32'(io_misaligned), 32'(m_halt));
`endif
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pc   = RST_PC;
      m_halt = 1'b0;
    end else if (rv) begin
      mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc   = rpc;
      m_halt = (rpc[1:0] != 2'b00);
`else
      m_pc   = {rpc[31:2], 2'b00};
`endif
    end else begin
      if (exp_valid && rdy) void'(mq.pop_front());
      if (!m_halt && mq.size() < DEPTH) begin
        mq.push_back('{pc: m_pc, instr: mem[m_pc[11:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'(k) + 32'h100;

    // Reset sequence with decode always ready.
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_first_valid", 32'(last_valid), 32'h0);
    check("rst_addr0", last_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_pc0", last_pc, 32'h0);
    check("rst_instr0", last_instr, 32'h100);
    check("rst_addr1", last_addr, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_pc1", last_pc, 32'h4);
    check("rst_instr1", last_instr, 32'h101);
    check("rst_addr2", last_addr, 32'h2);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_pc2", last_pc, 32'h8);
    check("rst_instr2", last_instr, 32'h102);

    // Mid-run reset, then backpressure until the queue saturates.
    step(1'b1, 1'b1, 32'h40, 1'b1);
    repeat (7) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("bp_head_pc", last_pc, 32'h0);
    check("bp_head_instr", last_instr, 32'h100);
    check("bp_addr_hold", last_addr, 32'h2);
    // Release: full queue pops and pushes every cycle.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_rel_pc0", last_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_rel_pc1", last_pc, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_rel_pc2", last_pc, 32'h8);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while the queue is full.
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    check("redir_valid_n", 32'(last_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_valid_n1", 32'(last_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_valid_n2", 32'(last_valid), 32'h1);
    check("redir_pc", last_pc, 32'h40);
    check("redir_instr", last_instr, 32'h110);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_addr_top", last_addr, 32'h3FFF_FFFF);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_pc_top", last_pc, 32'hFFFF_FFFC);
    check("wrap_instr_top", last_instr, 32'h4FF);
    check("wrap_addr_zero", last_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_pc_zero", last_pc, 32'h0);

    // Misaligned redirect target.
    step(1'b0, 1'b1, 32'h42, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis_flag", 32'(io_misaligned), 32'h1);
    check("mis_no_push", 32'(last_valid), 32'h0);
    step(1'b0, 1'b1, 32'h80, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis_clear", 32'(io_misaligned), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis_resume_pc", last_pc, 32'h80);
    check("mis_resume_instr", last_instr, 32'h120);
`else
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("align_pc", last_pc, 32'h40);
    check("align_instr", last_instr, 32'h110);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_rv, r_rdy;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) < 2);
      r_rv  = ($urandom_range(0, 99) < 8);
      r_rdy = ($urandom_range(0, 99) < 70);
      r_pc  = $urandom;
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      step(r_rst, r_rv, r_pc, r_rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
